// File: rtl/timer_pkg.sv
// Shared definitions for the two-mode MM:SS timer: FSM state encoding,
// flasher rate codes, the seconds ceiling and the preset-minute clamp.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] TC_RUN   = 3'b000;
    localparam logic [2:0] TC_PAUSE = 3'b010;
    localparam logic [2:0] TC_DONE  = 3'b100;

    localparam logic [7:0] SEC_MAX = 8'd59;

    // A zero preset loads as one minute; anything above the minute ceiling is held at the ceiling.
    function automatic logic [7:0] clamp_preset(input logic [7:0] preset, input logic [7:0] max_min);
        logic [7:0] result;
        result = (preset == 8'd0) ? 8'd1 : preset;
        if (result > max_min)
            result = max_min;
        return result;
    endfunction

endpackage

// File: rtl/mmss_counter.sv
// Loadable up/down minutes:seconds counter. Clear has priority over load,
// load over counting. Stepping never wraps past MAX_MIN:59 nor below 00:00.
module mmss_counter
    import timer_pkg::*;
#(
    parameter int MAX_MIN = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       up,
    input  logic       load,
    input  logic [7:0] load_min,
    input  logic       clr,
    output logic [7:0] min,
    output logic [7:0] sec,
    output logic       at_max,
    output logic       at_zero
);

    localparam logic [7:0] MIN_CEIL = 8'(MAX_MIN);

    assign at_max  = (min == MIN_CEIL) && (sec == SEC_MAX);
    assign at_zero = (min == 8'd0) && (sec == 8'd0);

    // Count register: clear, then preset load, then a single up or down step per enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min <= 8'd0;
            sec <= 8'd0;
        end else if (clr) begin
            min <= 8'd0;
            sec <= 8'd0;
        end else if (load) begin
            min <= clamp_preset(load_min, MIN_CEIL);
            sec <= 8'd0;
        end else if (en) begin
            if (up) begin
                if (!at_max) begin
                    if (sec < SEC_MAX) begin
                        sec <= sec + 8'd1;
                    end else begin
                        sec <= 8'd0;
                        min <= min + 8'd1;
                    end
                end
            end else begin
                if (!at_zero) begin
                    if (sec > 8'd0) begin
                        sec <= sec - 8'd1;
                    end else begin
                        sec <= SEC_MAX;
                        min <= min - 8'd1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/timer_sequencer.sv
// Run/pause/clear controller for the two-mode timer. Mode A counts up and
// stops at MAX_MIN:59, mode B counts down from a preset and stops at 00:00.
// Optional macro TIMER_PRESCALE_EN replaces the external 1 Hz tick with an
// internal PRESCALE-cycle divider that only runs while counting.
module timer_sequencer
    import timer_pkg::*;
#(
    parameter int MAX_MIN  = 99,
    parameter int PRESCALE = 50_000_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Tick1Hz,
    input  logic       StartStop,
    input  logic       Clear,
    input  logic       ModeSel,
    input  logic [7:0] PresetMin,
    output logic [7:0] MSB,
    output logic [7:0] LSB,
    output logic       Stopped,
    output logic [2:0] TimeControl,
    output logic       Done
);

    localparam logic [7:0] MIN_CEIL = 8'(MAX_MIN);

    state_t     state;
    state_t     state_nxt;
    logic       mode_down;
    logic       tick;
    logic       start_run;
    logic       term_step;
    logic       cnt_en;
    logic       cnt_load;
    logic       at_max;
    logic       at_zero;
    logic       stopped_nxt;
    logic [2:0] tc_nxt;
    logic       done_nxt;

    assign start_run = (state == ST_IDLE) && StartStop && !Clear;
    assign cnt_en    = (state == ST_RUN) && tick && !Clear;
    assign cnt_load  = start_run && ModeSel;

    // The step about to be taken lands on the terminal count (or is already there).
    assign term_step = mode_down ? (((MSB == 8'd0) && (LSB == 8'd1)) || at_zero)
                                 : (((MSB == MIN_CEIL) && (LSB == SEC_MAX - 8'd1)) || at_max);

`ifdef TIMER_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] pre_cnt;
    logic          unused_tick_in;

    assign unused_tick_in = Tick1Hz;
    assign tick = (state == ST_RUN) && (pre_cnt == PW'(PRESCALE - 1));

    // Prescaler restarts on clear and on every fresh start so the first second is a full one.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            pre_cnt <= '0;
        else if (Clear || start_run)
            pre_cnt <= '0;
        else if (state == ST_RUN)
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
    end
`else
    logic [31:0] unused_prescale;

    assign unused_prescale = 32'(PRESCALE);
    assign tick = Tick1Hz;
`endif

    mmss_counter #(
        .MAX_MIN (MAX_MIN)
    ) u_count (
        .clk      (CLK),
        .rst      (RST),
        .en       (cnt_en),
        .up       (!mode_down),
        .load     (cnt_load),
        .load_min (PresetMin),
        .clr      (Clear),
        .min      (MSB),
        .sec      (LSB),
        .at_max   (at_max),
        .at_zero  (at_zero)
    );

    // State, mode latch and the registered flasher decodes.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= ST_IDLE;
            mode_down   <= 1'b0;
            Stopped     <= 1'b1;
            TimeControl <= TC_RUN;
            Done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            Stopped     <= stopped_nxt;
            TimeControl <= tc_nxt;
            Done        <= done_nxt;
            if (start_run)
                mode_down <= ModeSel;
        end
    end

    // Next state: Clear dominates; reaching the terminal count outranks a pause press.
    always_comb begin
        state_nxt = state;
        if (Clear) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (StartStop) state_nxt = ST_RUN;
                ST_RUN: begin
                    if (tick && term_step)
                        state_nxt = ST_DONE;
                    else if (StartStop)
                        state_nxt = ST_PAUSE;
                end
                ST_PAUSE: if (StartStop) state_nxt = ST_RUN;
                ST_DONE:  state_nxt = ST_DONE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // Flasher controls decoded from the state being entered.
    always_comb begin
        stopped_nxt = 1'b1;
        tc_nxt      = TC_RUN;
        done_nxt    = 1'b0;
        case (state_nxt)
            ST_IDLE: begin
                stopped_nxt = 1'b1;
                tc_nxt      = TC_RUN;
            end
            ST_RUN: begin
                stopped_nxt = 1'b0;
                tc_nxt      = TC_RUN;
            end
            ST_PAUSE: begin
                stopped_nxt = 1'b1;
                tc_nxt      = TC_PAUSE;
            end
            ST_DONE: begin
                stopped_nxt = 1'b0;
                tc_nxt      = TC_DONE;
                done_nxt    = 1'b1;
            end
            default: begin
                stopped_nxt = 1'b1;
                tc_nxt      = TC_RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_timer_sequencer.sv
// Bench for timer_sequencer: a full-size instance and a MAX_MIN=2 instance
// share all inputs and are compared against a total-seconds reference model.
module tb_timer_sequencer;

    logic       CLK = 1'b0;
    logic       RST;
    logic       Tick1Hz;
    logic       StartStop;
    logic       Clear;
    logic       ModeSel;
    logic [7:0] PresetMin;

    logic [7:0] msb0, lsb0, msb1, lsb1;
    logic       stopped0, stopped1, done0, done1;
    logic [2:0] tc0, tc1;

    int vectors     = 0;
    int miscompares = 0;

    typedef enum int {P_IDLE, P_RUN, P_PAUSE, P_DONE} phase_t;

    phase_t m_phase [2];
    int     m_total [2];
    bit     m_down  [2];
    int     m_max   [2] = '{99, 2};

    localparam logic [20:0] RESET_VEC = {8'd0, 8'd0, 1'b1, 3'b000, 1'b0};

    timer_sequencer #(.MAX_MIN(99)) dut (
        .CLK(CLK), .RST(RST), .Tick1Hz(Tick1Hz), .StartStop(StartStop),
        .Clear(Clear), .ModeSel(ModeSel), .PresetMin(PresetMin),
        .MSB(msb0), .LSB(lsb0), .Stopped(stopped0), .TimeControl(tc0), .Done(done0)
    );

    timer_sequencer #(.MAX_MIN(2)) dut_small (
        .CLK(CLK), .RST(RST), .Tick1Hz(Tick1Hz), .StartStop(StartStop),
        .Clear(Clear), .ModeSel(ModeSel), .PresetMin(PresetMin),
        .MSB(msb1), .LSB(lsb1), .Stopped(stopped1), .TimeControl(tc1), .Done(done1)
    );

    always #5 CLK = ~CLK;

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = P_IDLE;
            m_total[i] = 0;
            m_down[i]  = 1'b0;
        end
    endfunction

    // Time is one integer of seconds; a mode A run ends at the last second of the last minute.
    function automatic void model_step();
        for (int i = 0; i < 2; i++) begin
            int limit;
            int p;
            phase_t nxt;
            limit = m_max[i] * 60 + 59;
            if (Clear) begin
                m_phase[i] = P_IDLE;
                m_total[i] = 0;
            end else begin
                case (m_phase[i])
                    P_IDLE: if (StartStop) begin
                        m_phase[i] = P_RUN;
                        m_down[i]  = ModeSel;
                        if (ModeSel) begin
                            p = (PresetMin == 0) ? 1 : int'(PresetMin);
                            if (p > m_max[i]) p = m_max[i];
                            m_total[i] = p * 60;
                        end
                    end
                    P_RUN: begin
                        nxt = StartStop ? P_PAUSE : P_RUN;
                        if (Tick1Hz) begin
                            if (!m_down[i]) begin
                                if (m_total[i] < limit) m_total[i]++;
                                if (m_total[i] == limit) nxt = P_DONE;
                            end else begin
                                if (m_total[i] > 0) m_total[i]--;
                                if (m_total[i] == 0) nxt = P_DONE;
                            end
                        end
                        m_phase[i] = nxt;
                    end
                    P_PAUSE: if (StartStop) m_phase[i] = P_RUN;
                    default: ;
                endcase
            end
        end
    endfunction

    function automatic logic [20:0] expect_vec(input int i);
        logic       st;
        logic [2:0] tc;
        logic       dn;
        st = (m_phase[i] == P_IDLE) || (m_phase[i] == P_PAUSE);
        tc = (m_phase[i] == P_PAUSE) ? 3'b010 : (m_phase[i] == P_DONE) ? 3'b100 : 3'b000;
        dn = (m_phase[i] == P_DONE);
        return {8'(m_total[i] / 60), 8'(m_total[i] % 60), st, tc, dn};
    endfunction

    function automatic logic [20:0] actual_vec(input int i);
        if (i == 0) return {msb0, lsb0, stopped0, tc0, done0};
        return {msb1, lsb1, stopped1, tc1, done1};
    endfunction

    task automatic step(input bit ss, input bit clr, input bit tk);
        StartStop = ss;
        Clear     = clr;
        Tick1Hz   = tk;
        model_step();
        @(posedge CLK);
        #1;
        StartStop = 1'b0;
        Clear     = 1'b0;
        Tick1Hz   = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        RST = 1'b1; Tick1Hz = 0; StartStop = 0; Clear = 0; ModeSel = 0; PresetMin = 8'd1;
        model_reset();
        #1;
        vectors++;
        if (actual_vec(0) !== RESET_VEC) begin
            miscompares++;
            $display("[TB] FAIL reset_initial got %h want %h", actual_vec(0), RESET_VEC);
        end
        @(negedge CLK); RST = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        ticks(7);
        vectors++;
        if (actual_vec(0) !== expect_vec(0)) begin
            miscompares++;
            $display("[TB] FAIL run_0007 got %h want %h", actual_vec(0), expect_vec(0));
        end
        #2 RST = 1'b1;
        #1;
        vectors++;
        if (actual_vec(0) !== RESET_VEC || actual_vec(1) !== RESET_VEC) begin
            miscompares++;
            $display("[TB] FAIL reset_async got %h/%h want %h", actual_vec(0), actual_vec(1), RESET_VEC);
        end
        model_reset();
        @(negedge CLK); RST = 1'b0;
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_mode_a();
        ModeSel = 1'b0;
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        ticks(61);
        vectors++;
        if ({msb0, lsb0} !== 16'h0101 || actual_vec(0) !== expect_vec(0)) begin
            miscompares++;
            $display("[TB] FAIL modeA_61 got %h want %h", actual_vec(0), expect_vec(0));
        end
        step(1'b1, 1'b0, 1'b0);
        ticks(5);
        vectors++;
        if ({msb0, lsb0, stopped0, tc0} !== {16'h0101, 1'b1, 3'b010}) begin
            miscompares++;
            $display("[TB] FAIL modeA_pause got %h want %h", actual_vec(0), expect_vec(0));
        end
        step(1'b1, 1'b0, 1'b0);
        ticks(1);
        vectors++;
        if ({msb0, lsb0} !== 16'h0102 || actual_vec(0) !== expect_vec(0)) begin
            miscompares++;
            $display("[TB] FAIL modeA_resume got %h want %h", actual_vec(0), expect_vec(0));
        end
    endtask

    task automatic test_mode_b();
        ModeSel = 1'b1; PresetMin = 8'd1;
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        vectors++;
        if ({msb0, lsb0} !== 16'h0100 || actual_vec(1) !== expect_vec(1)) begin
            miscompares++;
            $display("[TB] FAIL modeB_load got %h want %h", actual_vec(0), expect_vec(0));
        end
        ticks(1);
        vectors++;
        if ({msb0, lsb0} !== {8'd0, 8'd59}) begin
            miscompares++;
            $display("[TB] FAIL modeB_first got %h want 003b", {msb0, lsb0});
        end
        ticks(59);
        vectors++;
        if (actual_vec(0) !== {8'd0, 8'd0, 1'b0, 3'b100, 1'b1} || actual_vec(1) !== expect_vec(1)) begin
            miscompares++;
            $display("[TB] FAIL modeB_done got %h want %h", actual_vec(0), expect_vec(0));
        end
        ticks(3);
        step(1'b1, 1'b0, 1'b1);
        vectors++;
        if (actual_vec(0) !== {8'd0, 8'd0, 1'b0, 3'b100, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL modeB_hold got %h want %h", actual_vec(0), expect_vec(0));
        end
    endtask

    task automatic test_max_limit();
        ModeSel = 1'b0;
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        ticks(178);
        vectors++;
        if ({msb1, lsb1, done1} !== {8'd2, 8'd58, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL max_0258 got %h want %h", actual_vec(1), expect_vec(1));
        end
        ticks(1);
        vectors++;
        if (actual_vec(1) !== {8'd2, 8'd59, 1'b0, 3'b100, 1'b1} || actual_vec(0) !== expect_vec(0)) begin
            miscompares++;
            $display("[TB] FAIL max_done got %h want %h", actual_vec(1), expect_vec(1));
        end
        ticks(4);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        vectors++;
        if (actual_vec(1) !== {8'd2, 8'd59, 1'b0, 3'b100, 1'b1} || actual_vec(0) !== expect_vec(0)) begin
            miscompares++;
            $display("[TB] FAIL max_hold got %h want %h", actual_vec(1), expect_vec(1));
        end
    endtask

    task automatic test_same_cycle();
        ModeSel = 1'b0;
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        vectors++;
        if (actual_vec(0) !== {8'd0, 8'd0, 1'b0, 3'b000, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL start_tick got %h want %h", actual_vec(0), expect_vec(0));
        end
        ticks(5);
        step(1'b1, 1'b1, 1'b1);
        vectors++;
        if (actual_vec(0) !== RESET_VEC || actual_vec(1) !== expect_vec(1)) begin
            miscompares++;
            $display("[TB] FAIL clear_wins got %h want %h", actual_vec(0), RESET_VEC);
        end
        step(1'b1, 1'b0, 1'b0);
        ticks(10);
        step(1'b1, 1'b0, 1'b1);
        vectors++;
        if (actual_vec(0) !== {8'd0, 8'd11, 1'b1, 3'b010, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL pause_tick got %h want %h", actual_vec(0), expect_vec(0));
        end
    endtask

    task automatic test_mode_latch();
        ModeSel = 1'b0; PresetMin = 8'd5;
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        ticks(5);
        ModeSel = 1'b1;
        ticks(5);
        vectors++;
        if ({msb0, lsb0} !== 16'h000a) begin
            miscompares++;
            $display("[TB] FAIL mode_ignored got %h want 000a", {msb0, lsb0});
        end
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        vectors++;
        if ({msb0, lsb0, msb1, lsb1} !== 32'h0500_0200) begin
            miscompares++;
            $display("[TB] FAIL preset_load got %h want 05000200", {msb0, lsb0, msb1, lsb1});
        end
        PresetMin = 8'd0;
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        vectors++;
        if ({msb0, lsb0} !== 16'h0100 || actual_vec(1) !== expect_vec(1)) begin
            miscompares++;
            $display("[TB] FAIL preset_zero got %h want 0100", {msb0, lsb0});
        end
    endtask

    task automatic test_random();
        step(1'b0, 1'b1, 1'b0);
        for (int n = 0; n < 3000; n++) begin
            ModeSel   = 1'($urandom_range(0, 1));
            PresetMin = 8'($urandom_range(0, 4));
            step($urandom_range(0, 7) == 0, $urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1);
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (actual_vec(i) !== expect_vec(i)) begin
                    miscompares++;
                    $display("[TB] FAIL random_%0d cycle %0d got %h want %h", i, n, actual_vec(i), expect_vec(i));
                end
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_mode_a();
        test_mode_b();
        test_max_limit();
        test_same_cycle();
        test_mode_latch();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
